apb_slave_regfile: RTL and testbench



---
 rtl/apb_slave_pkg.sv | 29 ++
 rtl/apb_slv_regmem.sv | 36 +++
 rtl/apb_slave_regfile.sv | 149 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and address decode for the APB register-file completer.
// Decode assumes 64-bit words (WORD_BYTES = 8); DATA_W must match.
package apb_slave_pkg;

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_e;

  localparam int WORD_BYTES = 8;
  localparam int OFF_LSB    = $clog2(WORD_BYTES);

  typedef struct packed {
    logic        err;
    logic [31:0] idx;
  } dec_t;

  // Flags below-base, misaligned and past-the-end accesses in one place.
  function automatic dec_t addr_decode(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input int unsigned depth);
    logic [63:0] off;
    logic [63:0] word;
    dec_t        d;
    off   = addr - base;
    word  = off >> OFF_LSB;
    d.err = (addr < base) || (off[OFF_LSB-1:0] != '0) || (word >= 64'(depth));
    d.idx = word[31:0];
    return d;
  endfunction

endpackage

// File: rtl/apb_slv_regmem.sv
// DEPTH x DATA_W register storage: byte-enabled synchronous write,
// combinational read, synchronous active-low clear.
module apb_slv_regmem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [31:0]         wr_idx_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  input  logic [31:0]         rd_idx_i,
  output logic [DATA_W-1:0]   rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (wr_idx_i == i)
          for (int b = 0; b < DATA_W/8; b++)
            if (wr_be_i[b]) mem_q[i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (rd_idx_i == i) rd_data_o = mem_q[i];
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer over a word-addressed register file with programmable wait
// states. Define APB_SLV_PSTRB_EN to add the PSTRB byte-strobe input.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int          ADDR_W      = 64,
  parameter int          DATA_W      = 64,
  parameter int          DEPTH       = 16,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [31:0]         idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                slverr_q, slverr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_we;
  logic [31:0]         rd_idx;
  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W/8-1:0] be;
  logic                setup;
  dec_t                dec_bus;

  assign dec_bus = addr_decode(64'(PADDR), BASE_ADDR, unsigned'(DEPTH));
  assign setup   = (state_q == S_IDLE) && PSEL && !PENABLE;
  // Zero-wait reads sample the array in the setup cycle, before idx_q exists.
  assign rd_idx  = (state_q == S_IDLE) ? dec_bus.idx : idx_q;

`ifdef APB_SLV_PSTRB_EN
  logic [DATA_W/8-1:0] strb_q;
  always_ff @(posedge PCLK) begin
    if (!PRESETn)   strb_q <= '0;
    else if (setup) strb_q <= PSTRB;
  end
  assign be = strb_q;
`else
  assign be = '1;
`endif

  apb_slv_regmem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .clk_i     (PCLK),
    .rst_ni    (PRESETn),
    .we_i      (mem_we),
    .wr_idx_i  (idx_q),
    .wr_data_i (wdata_q),
    .wr_be_i   (be),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    err_d    = err_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    ready_d  = ready_q;
    slverr_d = slverr_q;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          state_d = S_ACCESS;
          write_d = PWRITE;
          err_d   = dec_bus.err;
          idx_d   = dec_bus.idx;
          wdata_d = PWDATA;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            ready_d  = 1'b1;
            slverr_d = dec_bus.err;
            if (!PWRITE) rdata_d = dec_bus.err ? '0 : rd_data;
          end
        end
      end
      default: begin
        if (!PSEL) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          slverr_d = 1'b0;
        end else if (PENABLE) begin
          if (ready_q) begin
            mem_we   = write_q && !err_q;
            state_d  = S_IDLE;
            ready_d  = 1'b0;
            slverr_d = 1'b0;
          end else begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
              ready_d  = 1'b1;
              slverr_d = err_q;
              if (!write_q) rdata_d = err_q ? '0 : rd_data;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign PRDATA  = rdata_q;
  assign PREADY  = ready_q;
  assign PSLVERR = slverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: dut1 has one wait state at base 0, dut3 has three wait
// states at base 0x1000. Both share the bus except for their PSEL.
module tb_apb_slave_regfile;

  logic        PCLK = 1'b0;
  logic        PRESETn, PENABLE, PWRITE, psel1, psel3;
  logic [63:0] PADDR, PWDATA;
  logic [63:0] rdata1, rdata3;
  logic        rdy1, rdy3, err1, err3;
`ifdef APB_SLV_PSTRB_EN
  logic [7:0]  PSTRB;
`endif
  int tests = 0;
  int fails = 0;

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(.WAIT_CYCLES(1), .BASE_ADDR(64'h0)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel1), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(rdata1), .PREADY(rdy1), .PSLVERR(err1));

  apb_slave_regfile #(.WAIT_CYCLES(3), .BASE_ADDR(64'h1000)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(rdata3), .PREADY(rdy3), .PSLVERR(err3));

  // One transfer; starts and ends 1 time unit after a rising edge, so calls chain back-to-back.
  task automatic xfer(input int w, input bit wr, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] rd, output logic er, output int waits);
    bit done;
    PADDR = a; PWDATA = d; PWRITE = wr; PENABLE = 1'b0;
    psel1 = (w == 1); psel3 = (w == 3);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PWDATA  = ~d;
    waits = 0; done = 1'b0; rd = 'x; er = 1'bx;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge PCLK);
      if ((w == 1) ? rdy1 : rdy3) begin
        rd   = (w == 1) ? rdata1 : rdata3;
        er   = (w == 1) ? err1 : err3;
        done = 1'b1;
      end else waits++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL xfer_timeout addr=%h: PREADY never rose within 20 cycles", a);
    end
    @(posedge PCLK); #1;
    psel1 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] rd; logic er; int w;
    PRESETn = 1'b0; psel1 = 0; psel3 = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    repeat (2) @(posedge PCLK); #1;
    tests++; if ({rdy1, err1, rdy3, err3} !== 4'b0) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {rdy1, err1, rdy3, err3}); end
    tests++; if (rdata1 !== 64'h0) begin fails++; $display("FAIL reset_prdata got=%h exp=0", rdata1); end
    PRESETn = 1'b1;
    xfer(1, 1, 64'h08, 64'h1234, rd, er, w);
    xfer(1, 0, 64'h08, 64'h0, rd, er, w);
    tests++; if (rd !== 64'h1234) begin fails++; $display("FAIL pre_reset_read got=%h exp=1234", rd); end
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK); #1;
    tests++; if (rdata1 !== 64'h0 || rdy1 !== 1'b0) begin fails++; $display("FAIL reset2_out prdata=%h pready=%b exp 0/0", rdata1, rdy1); end
    PRESETn = 1'b1;
    xfer(1, 0, 64'h08, 64'h0, rd, er, w);
    tests++; if (rd !== 64'h0 || er !== 1'b0) begin fails++; $display("FAIL reset_read08 got=%h err=%b exp=0 err=0", rd, er); end
  endtask

  task automatic test_write_read();
    logic [63:0] rd; logic er; int w;
    xfer(1, 1, 64'h30, 64'h45, rd, er, w);
    tests++; if (er !== 1'b0 || w != 1) begin fails++; $display("FAIL wr30 err=%b waits=%0d exp err=0 waits=1", er, w); end
    tests++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL wr30_ready_drop got=%b exp=0", rdy1); end
    xfer(1, 0, 64'h30, 64'h0, rd, er, w);
    tests++; if (rd !== 64'h45 || er !== 1'b0 || w != 1) begin fails++; $display("FAIL rd30 got=%h err=%b waits=%0d exp=45 err=0 waits=1", rd, er, w); end
  endtask

  task automatic test_misaligned();
    logic [63:0] rd; logic er; int w;
    xfer(1, 1, 64'h34, 64'h99, rd, er, w);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL wr34_err got=%b exp=1", er); end
    xfer(1, 0, 64'h30, 64'h0, rd, er, w);
    tests++; if (rd !== 64'h45 || er !== 1'b0) begin fails++; $display("FAIL rd30_after_misaligned got=%h err=%b exp=45 err=0", rd, er); end
  endtask

  task automatic test_range();
    logic [63:0] rd; logic er; int w;
    xfer(1, 0, 64'h80, 64'h0, rd, er, w);
    tests++; if (rd !== 64'h0 || er !== 1'b1) begin fails++; $display("FAIL rd80 got=%h err=%b exp=0 err=1", rd, er); end
    xfer(1, 1, 64'h78, 64'hABCD, rd, er, w);
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL wr78_err got=%b exp=0", er); end
    xfer(1, 0, 64'h78, 64'h0, rd, er, w);
    tests++; if (rd !== 64'hABCD || er !== 1'b0) begin fails++; $display("FAIL rd78 got=%h err=%b exp=abcd err=0", rd, er); end
    xfer(3, 0, 64'h0FF8, 64'h0, rd, er, w);
    tests++; if (rd !== 64'h0 || er !== 1'b1) begin fails++; $display("FAIL rd_below_base got=%h err=%b exp=0 err=1", rd, er); end
  endtask

  task automatic test_wait3();
    logic [63:0] rd; logic er; int w;
    PADDR = 64'h1010; PWDATA = 64'hDEADBEEF; PWRITE = 1'b1; PENABLE = 1'b0; psel3 = 1'b1;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(negedge PCLK);
    tests++; if (rdy3 !== 1'b0) begin fails++; $display("FAIL abort_wait1 pready=%b exp=0", rdy3); end
    @(posedge PCLK); #1 psel3 = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    tests++; if (rdy3 !== 1'b0 || err3 !== 1'b0) begin fails++; $display("FAIL abort_idle pready=%b pslverr=%b exp 0/0", rdy3, err3); end
    xfer(3, 0, 64'h1010, 64'h0, rd, er, w);
    tests++; if (rd !== 64'h0 || w != 3) begin fails++; $display("FAIL abort_readback got=%h waits=%0d exp=0 waits=3", rd, w); end
    xfer(3, 1, 64'h1010, 64'hDEADBEEF, rd, er, w);
    tests++; if (er !== 1'b0 || w != 3) begin fails++; $display("FAIL wr1010 err=%b waits=%0d exp err=0 waits=3", er, w); end
    tests++; if (rdy3 !== 1'b0) begin fails++; $display("FAIL wr1010_ready_1cyc got=%b exp=0", rdy3); end
    xfer(3, 0, 64'h1010, 64'h0, rd, er, w);
    tests++; if (rd !== 64'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL rd1010 got=%h err=%b exp=deadbeef err=0", rd, er); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic er; int w;
    xfer(1, 1, 64'h28, 64'hA5A5, rd, er, w);
    xfer(1, 0, 64'h28, 64'h0, rd, er, w);
    tests++; if (rd !== 64'hA5A5) begin fails++; $display("FAIL b2b_rd1 got=%h exp=a5a5", rd); end
    xfer(1, 1, 64'h28, 64'h5A5A, rd, er, w);
    xfer(1, 0, 64'h28, 64'h0, rd, er, w);
    tests++; if (rd !== 64'h5A5A) begin fails++; $display("FAIL b2b_rd2 got=%h exp=5a5a", rd); end
  endtask

  task automatic test_reset_midxfer();
    logic [63:0] rd; logic er; int w;
    PADDR = 64'h18; PWDATA = 64'h77; PWRITE = 1'b1; PENABLE = 1'b0; psel1 = 1'b1;
    @(posedge PCLK); #1 PENABLE = 1'b1; PRESETn = 1'b0;
    @(posedge PCLK); #1;
    tests++; if ({rdy1, err1} !== 2'b00 || rdata1 !== 64'h0) begin fails++; $display("FAIL midreset_out pready=%b pslverr=%b prdata=%h exp 0", rdy1, err1, rdata1); end
    PRESETn = 1'b1; psel1 = 1'b0; PENABLE = 1'b0;
    xfer(1, 0, 64'h18, 64'h0, rd, er, w);
    tests++; if (rd !== 64'h0) begin fails++; $display("FAIL midreset_read18 got=%h exp=0", rd); end
  endtask

  task automatic test_strobe();
    logic [63:0] rd; logic er; int w;
`ifdef APB_SLV_PSTRB_EN
    PSTRB = 8'h0F;
    xfer(1, 1, 64'h00, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, w);
    PSTRB = 8'h00;
    xfer(1, 1, 64'h00, 64'h1234_5678_9ABC_DEF0, rd, er, w);
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL strb0_err got=%b exp=0", er); end
    PSTRB = 8'hFF;
    xfer(1, 0, 64'h00, 64'h0, rd, er, w);
    tests++; if (rd !== 64'h0000_0000_FFFF_FFFF) begin fails++; $display("FAIL strb_read got=%h exp=00000000ffffffff", rd); end
`else
    xfer(1, 1, 64'h00, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, w);
    xfer(1, 0, 64'h00, 64'h0, rd, er, w);
    tests++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL fullword_read got=%h exp=ffffffffffffffff", rd); end
`endif
  endtask

  initial begin
`ifdef APB_SLV_PSTRB_EN
    PSTRB = 8'hFF;
`endif
    test_reset();
    test_write_read();
    test_misaligned();
    test_range();
    test_wait3();
    test_back_to_back();
    test_reset_midxfer();
    test_strobe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
